// File: rtl/post_mac_pkg.sv
// post_mac_pkg: shared types and helpers for the post-MAC RX buffer
package post_mac_pkg;

    typedef enum logic [0:0] {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

    localparam int BEAT_DATA_W = 64;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]   data;
        logic [BEAT_DATA_W/8-1:0] keep;
        logic                     last;
    } beat_t;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/post_mac_pkt_ram.sv
// post_mac_pkt_ram: simple dual-port beat RAM, one write port and one registered read port
module post_mac_pkt_ram
    import post_mac_pkg::*;
#(
    parameter int  AW = 9,
    parameter type T  = beat_t
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  T              wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output T              rdata
);

    T mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The read register doubles as the output register, so it holds while not re-read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/post_mac_rx_buffer.sv
// post_mac_rx_buffer: store-and-forward MAC RX buffer releasing only complete, error-free frames
// Drop counters are built when POST_MAC_DROP_COUNT_EN is defined.
module post_mac_rx_buffer
    import post_mac_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int FIFO_DEPTH_LOG2 = 9
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
    input  logic                        axis_in_tuser,
    input  logic                        axis_in_tlast,
    input  logic                        axis_in_tvalid,
    output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep,
    output logic                        axis_out_tlast,
    output logic                        axis_out_tvalid,
`ifdef POST_MAC_DROP_COUNT_EN
    output logic [31:0]                 drop_bad_count,
    output logic [31:0]                 drop_ovf_count,
`endif
    input  logic                        axis_out_tready
);

    localparam int KW = AXIS_BUS_WIDTH / 8;
    localparam int PW = ptr_w(FIFO_DEPTH_LOG2);
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [AXIS_BUS_WIDTH-1:0] data;
        logic [KW-1:0]             keep;
        logic                      last;
    } rx_beat_t;

    rx_beat_t      wr_beat, rd_beat;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    wr_state_t     state;
    logic          full, accept, bad, ovf, wr_en, re;

    always_comb begin
        full    = (wr_ptr - rd_ptr) == DEPTH_P;
        accept  = axis_in_tvalid && state == ACCEPT;
        bad     = accept && axis_in_tlast && axis_in_tuser;
        ovf     = accept && full && !bad;
        wr_en   = accept && !full && !bad;
        re      = rd_ptr != commit_ptr && (!axis_out_tvalid || axis_out_tready);
        wr_beat = '{data: axis_in_tdata, keep: axis_in_tkeep, last: axis_in_tlast};
    end

    assign axis_out_tdata = rd_beat.data;
    assign axis_out_tkeep = rd_beat.keep;
    assign axis_out_tlast = rd_beat.last;

    // wr_ptr runs ahead speculatively; rolling it back to commit_ptr discards the frame whole
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr          <= '0;
            commit_ptr      <= '0;
            rd_ptr          <= '0;
            state           <= ACCEPT;
            axis_out_tvalid <= 1'b0;
        end else begin
            wr_ptr          <= bad || ovf ? commit_ptr : wr_en ? wr_ptr + 1'b1 : wr_ptr;
            commit_ptr      <= wr_en && axis_in_tlast ? wr_ptr + 1'b1 : commit_ptr;
            state           <= ovf && !axis_in_tlast ? DISCARD :
                               axis_in_tvalid && axis_in_tlast ? ACCEPT : state;
            rd_ptr          <= re ? rd_ptr + 1'b1 : rd_ptr;
            axis_out_tvalid <= re || (axis_out_tvalid && !axis_out_tready);
        end
    end

    post_mac_pkt_ram #(
        .AW(FIFO_DEPTH_LOG2),
        .T (rx_beat_t)
    ) u_ram (
        .clk  (aclk),
        .rst  (areset),
        .we   (wr_en),
        .waddr(wr_ptr[FIFO_DEPTH_LOG2-1:0]),
        .wdata(wr_beat),
        .re   (re),
        .raddr(rd_ptr[FIFO_DEPTH_LOG2-1:0]),
        .rdata(rd_beat)
    );

`ifdef POST_MAC_DROP_COUNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_bad_count <= '0;
            drop_ovf_count <= '0;
        end else begin
            drop_bad_count <= bad && drop_bad_count != '1 ? drop_bad_count + 32'd1 : drop_bad_count;
            drop_ovf_count <= ovf && drop_ovf_count != '1 ? drop_ovf_count + 32'd1 : drop_ovf_count;
        end
    end
`endif

endmodule

// File: tb/tb_post_mac_rx_buffer.sv
// tb_post_mac_rx_buffer: scoreboard bench for post_mac_rx_buffer with a 16-entry buffer
module tb_post_mac_rx_buffer;

    localparam int W  = 64;
    localparam int KW = W / 8;
    localparam int BW = W + KW + 1;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [W-1:0]  axis_in_tdata = '0;
    logic [KW-1:0] axis_in_tkeep = '0;
    logic          axis_in_tuser = 1'b0;
    logic          axis_in_tlast = 1'b0;
    logic          axis_in_tvalid = 1'b0;
    logic [W-1:0]  axis_out_tdata;
    logic [KW-1:0] axis_out_tkeep;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready = 1'b1;
`ifdef POST_MAC_DROP_COUNT_EN
    logic [31:0]   drop_bad_count;
    logic [31:0]   drop_ovf_count;
`endif

    always #5 aclk = ~aclk;

    post_mac_rx_buffer #(
        .AXIS_BUS_WIDTH (W),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .axis_in_tdata  (axis_in_tdata),
        .axis_in_tkeep  (axis_in_tkeep),
        .axis_in_tuser  (axis_in_tuser),
        .axis_in_tlast  (axis_in_tlast),
        .axis_in_tvalid (axis_in_tvalid),
        .axis_out_tdata (axis_out_tdata),
        .axis_out_tkeep (axis_out_tkeep),
        .axis_out_tlast (axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid),
`ifdef POST_MAC_DROP_COUNT_EN
        .drop_bad_count (drop_bad_count),
        .drop_ovf_count (drop_ovf_count),
`endif
        .axis_out_tready(axis_out_tready)
    );

    logic [BW-1:0] exp_q [$];
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input bit ok, input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkdata(input int f, input int b);
        return {8'hA5, 8'(f), 16'(b), 32'hC0DE_0000 + 32'(f * 256 + b)};
    endfunction

    function automatic logic [KW-1:0] mkkeep(input int b, input int n);
        return b == n - 1 ? 8'hFF >> (n % 8) : 8'hFF;
    endfunction

    function automatic logic [BW-1:0] cur_beat();
        return {axis_out_tlast, axis_out_tkeep, axis_out_tdata};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
        axis_in_tdata  = d;
        axis_in_tkeep  = k;
        axis_in_tlast  = l;
        axis_in_tuser  = u;
        axis_in_tvalid = 1'b1;
        idle(1);
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
        axis_in_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int f, input int n, input bit bad, input bit expect_out);
        for (int b = 0; b < n; b++) begin
            logic [W-1:0]  d;
            logic [KW-1:0] k;
            logic          l;
            d = mkdata(f, b);
            k = mkkeep(b, n);
            l = b == n - 1;
            if (expect_out) exp_q.push_back({l, k, d});
            beat(d, k, l, bad && l);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
        chk(exp_q.size() == 0, name, BW'(exp_q.size()), '0);
        idle(2);
        chk(axis_out_tvalid == 1'b0, "idle_after_drain", BW'(axis_out_tvalid), '0);
    endtask

    // Monitor: pops on every handshake and checks a stalled beat is held unchanged
    initial begin
        bit            stalled;
        logic [BW-1:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk(axis_out_tvalid == 1'b1, "hold_tvalid", BW'(axis_out_tvalid), BW'(1));
                    chk(cur_beat() == held, "hold_beat", cur_beat(), held);
                end
                if (axis_out_tvalid && axis_out_tready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", cur_beat(), '0);
                    end else begin
                        logic [BW-1:0] e;
                        e = exp_q.pop_front();
                        chk(cur_beat() == e, "out_beat", cur_beat(), e);
                    end
                end
                stalled = axis_out_tvalid && !axis_out_tready;
                held    = cur_beat();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk(axis_out_tvalid == 1'b0, "reset_tvalid", BW'(axis_out_tvalid), '0);
        chk(cur_beat() == '0, "reset_beat", cur_beat(), '0);
`ifdef POST_MAC_DROP_COUNT_EN
        chk(drop_bad_count == 0 && drop_ovf_count == 0, "reset_counts",
            BW'({drop_bad_count, drop_ovf_count}), '0);
`endif
        areset = 1'b0;
        idle(1);

        send_frame(1, 8, 0, 1);
        chk(axis_out_tvalid == 1'b0, "latency_edge_n", BW'(axis_out_tvalid), '0);
        idle(1);
        chk(axis_out_tvalid == 1'b1, "latency_edge_n1", BW'(axis_out_tvalid), BW'(1));
        chk(cur_beat() == {1'b0, mkkeep(0, 8), mkdata(1, 0)}, "latency_first_beat",
            cur_beat(), {1'b0, mkkeep(0, 8), mkdata(1, 0)});
        send_frame(2, 8, 0, 1);
        send_frame(3, 8, 0, 1);
        drain("drain_three_frames");

        send_frame(4, 8, 0, 1);
        send_frame(5, 8, 1, 0);
        send_frame(6, 8, 0, 1);
        drain("drain_bad_frame");
`ifdef POST_MAC_DROP_COUNT_EN
        chk(drop_bad_count == 1, "bad_count", BW'(drop_bad_count), BW'(1));
`endif

        axis_out_tready = 1'b0;
        send_frame(7, 20, 0, 0);
        send_frame(8, 4, 0, 1);
        idle(3);
        chk(axis_out_tvalid == 1'b1, "stall_valid", BW'(axis_out_tvalid), BW'(1));
        chk(cur_beat() == {1'b0, mkkeep(0, 4), mkdata(8, 0)}, "stall_first_beat",
            cur_beat(), {1'b0, mkkeep(0, 4), mkdata(8, 0)});
        axis_out_tready = 1'b1;
        drain("drain_long_frame");
`ifdef POST_MAC_DROP_COUNT_EN
        chk(drop_ovf_count == 1, "ovf_count_long", BW'(drop_ovf_count), BW'(1));
`endif

        axis_out_tready = 1'b0;
        send_frame(9, 8, 0, 1);
        send_frame(10, 4, 0, 1);
        send_frame(11, 8, 0, 0);
        idle(2);
        axis_out_tready = 1'b1;
        drain("drain_partial_fill");
`ifdef POST_MAC_DROP_COUNT_EN
        chk(drop_ovf_count == 2, "ovf_count_fill", BW'(drop_ovf_count), BW'(2));
        chk(drop_bad_count == 1, "bad_count_stable", BW'(drop_bad_count), BW'(1));
`endif

        fork
            begin
                repeat (60) begin
                    @(posedge aclk);
                    #1;
                    axis_out_tready = 1'($urandom_range(0, 1));
                end
                axis_out_tready = 1'b1;
            end
            for (int i = 0; i < 12; i++) send_frame(20 + i, 1, 0, 1);
        join
        drain("drain_single_beats");

        axis_out_tready = 1'b0;
        send_frame(40, 4, 0, 0);
        idle(2);
        chk(axis_out_tvalid == 1'b1, "pre_reset_valid", BW'(axis_out_tvalid), BW'(1));
        areset = 1'b1;
        #1;
        chk(axis_out_tvalid == 1'b0, "async_reset_valid", BW'(axis_out_tvalid), '0);
        chk(cur_beat() == '0, "async_reset_beat", cur_beat(), '0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        axis_out_tready = 1'b1;
        idle(4);
        chk(axis_out_tvalid == 1'b0, "post_reset_empty", BW'(axis_out_tvalid), '0);
`ifdef POST_MAC_DROP_COUNT_EN
        chk(drop_bad_count == 0 && drop_ovf_count == 0, "post_reset_counts",
            BW'({drop_bad_count, drop_ovf_count}), '0);
`endif
        send_frame(41, 3, 0, 1);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
